// File: rtl/dual_cam_wr_arbiter_if.sv
// rtl/dual_cam_wr_arbiter_if.sv - memory burst-write port shared by the arbiter and the memory controller
//
// Purpose: groups the burst write request/data/completion handshake.
// Ports (master = arbiter side):
//   mem_wr_req      master->slave  burst request, held until acknowledged
//   mem_wr_addr     master->slave  burst start word address (24)
//   mem_wr_len      master->slave  burst length in words (10)
//   mem_wr_ack      slave->master  one-cycle request accept
//   mem_wr_data_req slave->master  controller wants one word
//   mem_wr_data     master->slave  write data (16)
//   mem_wr_done     slave->master  one-cycle burst completion

interface dual_cam_wr_arbiter_if;
  logic        mem_wr_req;
  logic [23:0] mem_wr_addr;
  logic [9:0]  mem_wr_len;
  logic        mem_wr_ack;
  logic        mem_wr_data_req;
  logic [15:0] mem_wr_data;
  logic        mem_wr_done;

  modport master (
    output mem_wr_req, mem_wr_addr, mem_wr_len, mem_wr_data,
    input  mem_wr_ack, mem_wr_data_req, mem_wr_done
  );

  modport slave (
    input  mem_wr_req, mem_wr_addr, mem_wr_len, mem_wr_data,
    output mem_wr_ack, mem_wr_data_req, mem_wr_done
  );
endinterface

// File: rtl/dual_cam_wr_arbiter.sv
// rtl/dual_cam_wr_arbiter.sv - round-robin arbiter moving two camera FIFOs into frame buffers
//
// Purpose: grants one burst at a time to whichever camera FIFO holds a full
// burst, alternating when both do, and tracks a per-camera write pointer that
// advances per burst, wraps at the frame size and restarts on frame start.
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   cam0/1_frame_start                 frame-start pulses (clk domain)
//   cam0/1_fifo_cnt                    words available in each FIFO
//   cam0/1_fifo_data                   FIFO read data (one cycle after strobe)
//   cam0/1_fifo_rd                     FIFO read strobes
//   busy, active_cam                   not idle / selected camera
//   mem                                memory burst-write port (master)

module dual_cam_wr_arbiter #(
  parameter logic [9:0]  BURST_LEN   = 10'd256,
  parameter logic [23:0] FRAME_WORDS = 24'd307200,
  parameter logic [23:0] CAM0_BASE   = 24'h000000,
  parameter logic [23:0] CAM1_BASE   = 24'h080000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cam0_frame_start,
  input  logic                         cam1_frame_start,
  input  logic [9:0]                   cam0_fifo_cnt,
  input  logic [9:0]                   cam1_fifo_cnt,
  input  logic [15:0]                  cam0_fifo_data,
  input  logic [15:0]                  cam1_fifo_data,
  output logic                         cam0_fifo_rd,
  output logic                         cam1_fifo_rd,
  output logic                         busy,
  output logic                         active_cam,
  dual_cam_wr_arbiter_if.master        mem
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_XFER = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]  state;
  logic        sel;
  logic        last_served;
  logic [23:0] ptr [2];
  logic [1:0]  pend;
  logic [9:0]  word_cnt;

  logic        elig0, elig1;
  logic        rd_ok;
  logic [1:0]  fs_vec;
  logic [23:0] sel_ptr;
  logic [24:0] sel_ptr_sum;
  logic [23:0] sel_ptr_adv;

  assign elig0  = (cam0_fifo_cnt >= BURST_LEN);
  assign elig1  = (cam1_fifo_cnt >= BURST_LEN);
  assign fs_vec = {cam1_frame_start, cam0_frame_start};

  // Strobes beyond the burst length are swallowed so the FIFO never loses
  // words that belong to the next burst.
  assign rd_ok        = (state == S_XFER) && mem.mem_wr_data_req && (word_cnt < BURST_LEN);
  assign cam0_fifo_rd = rd_ok && !sel;
  assign cam1_fifo_rd = rd_ok && sel;

  assign sel_ptr     = ptr[sel];
  assign sel_ptr_sum = {1'b0, sel_ptr} + {15'd0, BURST_LEN};
  assign sel_ptr_adv = (sel_ptr_sum >= {1'b0, FRAME_WORDS}) ? 24'd0 : sel_ptr_sum[23:0];

  // Base + pointer intentionally wraps modulo 2^24.
  assign mem.mem_wr_addr = (sel ? CAM1_BASE : CAM0_BASE) + sel_ptr;
  assign mem.mem_wr_req  = (state == S_REQ);
  assign mem.mem_wr_len  = BURST_LEN;
  assign mem.mem_wr_data = sel ? cam1_fifo_data : cam0_fifo_data;

  assign busy       = (state != S_IDLE);
  assign active_cam = sel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      sel         <= 1'b0;
      last_served <= 1'b1;
      word_cnt    <= 10'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (elig0 && elig1) begin
            sel   <= ~last_served;
            state <= S_REQ;
          end else if (elig0) begin
            sel   <= 1'b0;
            state <= S_REQ;
          end else if (elig1) begin
            sel   <= 1'b1;
            state <= S_REQ;
          end
        end
        S_REQ: begin
          if (mem.mem_wr_ack) state <= S_XFER;
        end
        S_XFER: begin
          if (rd_ok) word_cnt <= word_cnt + 10'd1;
          if (mem.mem_wr_done) state <= S_DONE;
        end
        default: begin
          word_cnt    <= 10'd0;
          last_served <= sel;
          state       <= S_IDLE;
        end
      endcase
    end
  end

  // A frame start for the camera owning the current burst is deferred to
  // DONE so the in-flight address stays stable; a frame start arriving in
  // DONE itself also forces the pointer back to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr[0] <= 24'd0;
      ptr[1] <= 24'd0;
      pend   <= 2'b00;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if ((state == S_DONE) && (sel == 1'(i))) begin
          ptr[i]  <= (pend[i] || fs_vec[i]) ? 24'd0 : sel_ptr_adv;
          pend[i] <= 1'b0;
        end else if (fs_vec[i]) begin
          if (busy && (sel == 1'(i))) pend[i] <= 1'b1;
          else                        ptr[i]  <= 24'd0;
        end
      end
    end
  end

endmodule

// File: tb/tb_dual_cam_wr_arbiter.sv
// tb/tb_dual_cam_wr_arbiter.sv - directed self-checking bench for dual_cam_wr_arbiter

module tb_dual_cam_wr_arbiter;
  localparam logic [9:0]  BL  = 10'd256;
  localparam logic [23:0] FW  = 24'd307200;
  localparam logic [23:0] B0  = 24'h000000;
  localparam logic [23:0] B1  = 24'h080000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fs0, fs1;
  logic [9:0]  c0, c1;
  logic [15:0] d0, d1;
  logic        rd0, rd1, busy, active_cam;

  dual_cam_wr_arbiter_if mif ();

  dual_cam_wr_arbiter #(
    .BURST_LEN(BL), .FRAME_WORDS(FW), .CAM0_BASE(B0), .CAM1_BASE(B1)
  ) u_dut (
    .clk(clk), .rst_n(rst_n),
    .cam0_frame_start(fs0), .cam1_frame_start(fs1),
    .cam0_fifo_cnt(c0), .cam1_fifo_cnt(c1),
    .cam0_fifo_data(d0), .cam1_fifo_data(d1),
    .cam0_fifo_rd(rd0), .cam1_fifo_rd(rd1),
    .busy(busy), .active_cam(active_cam),
    .mem(mif)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Behavioural model: per-camera pointers, round-robin memory, burst phase
  int          m_ptr [2];
  int          m_last;
  bit          m_pend [2];
  bit          m_xfer;
  bit          m_in_burst;
  int          m_cur;
  logic [23:0] m_addr;
  int          m_words;
  int          rd_seen;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ptr[0] = 0; m_ptr[1] = 0;
    m_pend[0] = 0; m_pend[1] = 0;
    m_last = 1; m_xfer = 0; m_in_burst = 0; m_cur = 0;
  endtask

  task automatic predict();
    bit e0, e1;
    e0 = (c0 >= BL);
    e1 = (c1 >= BL);
    if (e0 && e1) m_cur = 1 - m_last;
    else if (e0)  m_cur = 0;
    else          m_cur = 1;
    m_addr = 24'((m_cur == 1 ? int'(B1) : int'(B0)) + m_ptr[m_cur]);
  endtask

  always @(posedge clk) begin
    #1;
    d0 = 16'($urandom);
    d1 = 16'($urandom);
  end

  always @(negedge clk) begin
    bit er;
    if (!rst_n) begin
      chk("rst_rd0", rd0, 0);
      chk("rst_rd1", rd1, 0);
      chk("rst_req", mif.mem_wr_req, 0);
      chk("rst_busy", busy, 0);
      chk("rst_active_cam", active_cam, 0);
    end else begin
      er = m_xfer && mif.mem_wr_data_req && (m_words < int'(BL));
      chk("fifo_rd0", rd0, 32'(er && m_cur == 0));
      chk("fifo_rd1", rd1, 32'(er && m_cur == 1));
      if (er) m_words++;
      if (rd0 || rd1) rd_seen++;
      if (mif.mem_wr_req) begin
        chk("req_addr", mif.mem_wr_addr, m_addr);
        chk("req_cam", active_cam, m_cur);
        chk("req_len", mif.mem_wr_len, BL);
      end
      if (m_xfer) chk("req_dropped", mif.mem_wr_req, 0);
      if (m_in_burst) begin
        chk("busy", busy, 1);
        chk("wr_data", mif.mem_wr_data, m_cur == 1 ? d1 : d0);
      end
    end
  end

  task automatic apply_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic pulse_fs(input int cam);
    if (cam == 0) fs0 = 1'b1; else fs1 = 1'b1;
    m_ptr[cam] = 0;
    @(posedge clk); #1;
    fs0 = 1'b0; fs1 = 1'b0;
  endtask

  task automatic do_burst(input int n_dreq, input int exp_rd, input int lit_cam, input int lit_addr,
                          input bit fs_mid, input bit fs_other_mid, input bit fs_done, input int abort_at);
    int t;
    predict();
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!mif.mem_wr_req && t < 40);
    if (!mif.mem_wr_req) begin
      chk("req_timeout", 0, 1);
      return;
    end
    if (lit_addr >= 0) chk("burst_addr_lit", mif.mem_wr_addr, lit_addr);
    if (lit_cam >= 0)  chk("burst_cam_lit", active_cam, lit_cam);
    m_in_burst = 1;
    @(posedge clk); #1 mif.mem_wr_ack = 1'b1;
    @(posedge clk); #1 mif.mem_wr_ack = 1'b0;
    m_words = 0; rd_seen = 0; m_xfer = 1;
    if (fs_mid) begin
      if (m_cur == 0) fs0 = 1'b1; else fs1 = 1'b1;
      m_pend[m_cur] = 1;
    end
    if (fs_other_mid) begin
      if (m_cur == 0) fs1 = 1'b1; else fs0 = 1'b1;
      m_ptr[1 - m_cur] = 0;
    end
    @(posedge clk); #1;
    fs0 = 1'b0; fs1 = 1'b0;
    for (int i = 0; i < n_dreq; i++) begin
      mif.mem_wr_data_req = 1'b1;
      if (i == abort_at) begin
        @(negedge clk); #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("abort_rd0", rd0, 0);
        chk("abort_rd1", rd1, 0);
        chk("abort_req", mif.mem_wr_req, 0);
        chk("abort_busy", busy, 0);
        chk("abort_strobes", rd_seen, abort_at + 1);
        mif.mem_wr_data_req = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        return;
      end
      @(posedge clk); #1;
    end
    mif.mem_wr_data_req = 1'b0;
    mif.mem_wr_done = 1'b1;
    @(posedge clk); #1;
    mif.mem_wr_done = 1'b0;
    m_xfer = 0;
    c0 = 10'd0; c1 = 10'd0;
    if (fs_done) begin
      if (m_cur == 0) fs0 = 1'b1; else fs1 = 1'b1;
    end
    @(posedge clk); #1;
    fs0 = 1'b0; fs1 = 1'b0;
    if (m_pend[m_cur] || fs_done) m_ptr[m_cur] = 0;
    else begin
      m_ptr[m_cur] += int'(BL);
      if (m_ptr[m_cur] >= int'(FW)) m_ptr[m_cur] = 0;
    end
    m_pend[m_cur] = 0;
    m_last = m_cur;
    m_in_burst = 0;
    chk("burst_strobes", rd_seen, exp_rd);
  endtask

  int lit_cams  [4] = '{0, 1, 0, 1};
  int lit_addrs [4] = '{32'h000000, 32'h080000, 32'h000100, 32'h080100};

  initial begin
    rst_n = 1'b0; fs0 = 0; fs1 = 0; c0 = 0; c1 = 0; d0 = 0; d1 = 0;
    mif.mem_wr_ack = 0; mif.mem_wr_data_req = 0; mif.mem_wr_done = 0;
    m_words = 0; rd_seen = 0; m_addr = 0;
    model_reset();
    apply_reset();

    // Reset state
    chk("init_busy", busy, 0);
    chk("init_req", mif.mem_wr_req, 0);
    chk("init_active_cam", active_cam, 0);
    chk("init_rd0", rd0, 0);

    // Single eligible camera, full 256-word burst, pointer advances by 256
    c0 = 10'd256; c1 = 10'd0;
    do_burst(256, 256, 0, 32'h000000, 0, 0, 0, -1);
    chk("model_ptr0", m_ptr[0], 256);
    c0 = 10'd256;
    do_burst(0, 0, 0, 32'h000100, 0, 0, 0, -1);

    // Round robin with both eligible
    apply_reset();
    for (int k = 0; k < 4; k++) begin
      c0 = 10'd300; c1 = 10'd300;
      do_burst(2, 2, lit_cams[k], lit_addrs[k], 0, 0, 0, -1);
    end

    // Excess data requests are not forwarded to the FIFO
    c0 = 10'd0; c1 = 10'd300;
    do_burst(300, 256, 1, 32'h080200, 0, 0, 0, -1);

    // Frame start for the selected camera during transfer is deferred
    apply_reset();
    c0 = 10'd256; do_burst(0, 0, 0, 32'h000000, 0, 0, 0, -1);
    c0 = 10'd256; do_burst(0, 0, 0, 32'h000100, 0, 0, 0, -1);
    c1 = 10'd256; do_burst(0, 0, 1, 32'h080000, 0, 0, 0, -1);
    c0 = 10'd256; do_burst(4, 4, 0, 32'h000200, 1, 0, 0, -1);
    c0 = 10'd256; do_burst(0, 0, 0, 32'h000000, 0, 0, 0, -1);
    c1 = 10'd256; do_burst(0, 0, 1, 32'h080100, 0, 0, 0, -1);

    // Frame start for the other camera mid-burst, and frame start in DONE
    c0 = 10'd256; do_burst(1, 1, 0, 32'h000100, 0, 1, 1, -1);
    c0 = 10'd256; do_burst(0, 0, 0, 32'h000000, 0, 0, 0, -1);
    c1 = 10'd256; do_burst(0, 0, 1, 32'h080000, 0, 0, 0, -1);
    pulse_fs(0);
    c0 = 10'd256; do_burst(0, 0, 0, 32'h000000, 0, 0, 0, -1);

    // Pointer wrap at the end of the frame
    apply_reset();
    for (int k = 0; k < 1199; k++) begin
      c0 = 10'd256; c1 = 10'd0;
      do_burst(0, 0, -1, -1, 0, 0, 0, -1);
    end
    c0 = 10'd256; do_burst(0, 0, 0, 32'h04AF00, 0, 0, 0, -1);
    c0 = 10'd256; do_burst(0, 0, 0, 32'h000000, 0, 0, 0, -1);

    // Reset in the middle of a transfer
    c0 = 10'd256; do_burst(10, 0, 0, 32'h000100, 0, 0, 0, 5);
    c0 = 10'd256; do_burst(0, 0, 0, 32'h000000, 0, 0, 0, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
